fir_mac_seq: RTL and testbench

- Sequencer and multiply-accumulate engine for one FIR filter channel, built around a 32-word x 18-bit SRL delay line.
- It sits directly downstream of the delay line and also drives it: it pushes each new input sample in, sweeps the tap address, and multiplies each tap by a coefficient from a distributed ROM.
- It accumulates the products and emits one scaled, saturated output per input sample.

---
 rtl/fir_mac_seq.sv | 181 ++++++++++++++++++
 tb/tb_fir_mac_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Sequencer and MAC engine for one FIR channel. Pushes samples into an external
// SRL delay line, sweeps the tap address, accumulates tap*coef, emits saturated output.
module fir_mac_seq #(
   parameter int NTAPS = 32,
   parameter int OW    = 24,
   parameter int SHIFT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [17:0]   din,
   input  logic                 stb,
   output logic [17:0]          sr_d,
   output logic                 sr_ce,
   output logic [4:0]           sr_a,
   input  logic signed [17:0]   sr_y,
   output logic [4:0]           ca,
   input  logic signed [17:0]   coef,
   output logic signed [OW-1:0] dout,
   output logic                 vld,
   output logic                 busy,
   output logic                 ovf
);

   localparam int ACCW = 41;
   localparam logic [4:0] LAST_A = 5'(NTAPS - 1);
   localparam logic signed [ACCW-1:0] OMAX = (41'sd1 <<< (OW - 1)) - 41'sd1;
   localparam logic signed [ACCW-1:0] OMIN = -(41'sd1 <<< (OW - 1));

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_MAC,
      ST_DRAIN
   } state_t;

   state_t                 state_q, state_d;
   logic [17:0]            sr_d_q, sr_d_d;
   logic                   sr_ce_q, sr_ce_d;
   logic [4:0]             sr_a_q, sr_a_d;
   logic signed [OW-1:0]   dout_q, dout_d;
   logic                   vld_q, vld_d;
   logic                   busy_q, busy_d;
   logic                   ovf_q, ovf_d;

   logic signed [17:0]     ys_q, ys_d;
   logic signed [17:0]     cs_q, cs_d;
   logic signed [35:0]     p_q, p_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic [2:1]             vld_pipe_q, vld_pipe_d;
   logic [2:1]             first_pipe_q, first_pipe_d;
   logic [2:1]             last_pipe_q, last_pipe_d;
   logic                   done_q, done_d;

   logic                   iss;
   logic signed [ACCW-1:0] p_ext;
   logic signed [ACCW-1:0] acc_sh;
   logic signed [OW-1:0]   sat_val;

   assign iss    = (state_q == ST_MAC);
   assign p_ext  = ACCW'(p_q);
   assign acc_sh = acc_q >>> SHIFT;

   always_comb begin
      sat_val = acc_sh[OW-1:0];
      if (acc_sh > OMAX)
         sat_val = OMAX[OW-1:0];
      else if (acc_sh < OMIN)
         sat_val = OMIN[OW-1:0];
   end

   // Control: sr_ce is only ever raised on the way into SHIFT.
   always_comb begin
      state_d = state_q;
      sr_d_d  = sr_d_q;
      sr_ce_d = 1'b0;
      sr_a_d  = sr_a_q;
      dout_d  = dout_q;
      vld_d   = 1'b0;
      busy_d  = busy_q;
      ovf_d   = ovf_q;
      if (stb && busy_q)
         ovf_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (stb) begin
               sr_d_d  = din;
               sr_ce_d = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_a_d  = '0;
            state_d = ST_MAC;
         end
         ST_MAC: begin
            if (sr_a_q == LAST_A)
               state_d = ST_DRAIN;
            else
               sr_a_d = sr_a_q + 5'd1;
         end
         ST_DRAIN: begin
            if (done_q) begin
               dout_d  = sat_val;
               vld_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: capture tap/coef, multiply, accumulate; tags ride alongside.
   always_comb begin
      ys_d         = ys_q;
      cs_d         = cs_q;
      p_d          = p_q;
      acc_d        = acc_q;
      vld_pipe_d   = {vld_pipe_q[1], iss};
      first_pipe_d = {first_pipe_q[1], iss && (sr_a_q == 5'd0)};
      last_pipe_d  = {last_pipe_q[1], iss && (sr_a_q == LAST_A)};
      done_d       = vld_pipe_q[2] && last_pipe_q[2];
      if (iss) begin
         ys_d = sr_y;
         cs_d = coef;
      end
      if (vld_pipe_q[1])
         p_d = ys_q * cs_q;
      if (vld_pipe_q[2])
         acc_d = first_pipe_q[2] ? p_ext : acc_q + p_ext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sr_d_q       <= '0;
         sr_ce_q      <= 1'b0;
         sr_a_q       <= '0;
         dout_q       <= '0;
         vld_q        <= 1'b0;
         busy_q       <= 1'b0;
         ovf_q        <= 1'b0;
         ys_q         <= '0;
         cs_q         <= '0;
         p_q          <= '0;
         acc_q        <= '0;
         vld_pipe_q   <= '0;
         first_pipe_q <= '0;
         last_pipe_q  <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_d_q       <= sr_d_d;
         sr_ce_q      <= sr_ce_d;
         sr_a_q       <= sr_a_d;
         dout_q       <= dout_d;
         vld_q        <= vld_d;
         busy_q       <= busy_d;
         ovf_q        <= ovf_d;
         ys_q         <= ys_d;
         cs_q         <= cs_d;
         p_q          <= p_d;
         acc_q        <= acc_d;
         vld_pipe_q   <= vld_pipe_d;
         first_pipe_q <= first_pipe_d;
         last_pipe_q  <= last_pipe_d;
         done_q       <= done_d;
      end
   end

   assign sr_d  = sr_d_q;
   assign sr_ce = sr_ce_q;
   assign sr_a  = sr_a_q;
   assign ca    = sr_a_q;
   assign dout  = dout_q;
   assign vld   = vld_q;
   assign busy  = busy_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: models the SRL delay line and coefficient ROM, and
// predicts each output as a plain saturated dot product of sample history and coefs.
module tb_fir_mac_seq;

   localparam int NTAPS = 32;
   localparam int OW    = 24;
   localparam int SHIFT = 16;
   localparam int LAT   = NTAPS + 4;
   localparam longint OMAX = (longint'(1) << (OW - 1)) - 1;
   localparam longint OMIN = -(longint'(1) << (OW - 1));

   logic                 clk;
   logic                 rst;
   logic signed [17:0]   din;
   logic                 stb;
   logic [17:0]          sr_d;
   logic                 sr_ce;
   logic [4:0]           sr_a;
   logic signed [17:0]   sr_y;
   logic [4:0]           ca;
   logic signed [17:0]   coef;
   logic signed [OW-1:0] dout;
   logic                 vld;
   logic                 busy;
   logic                 ovf;

   logic signed [17:0]   srl [32];
   logic signed [17:0]   ctab [32];
   logic                 srl_clr;
   longint               hist[$];
   longint               prev_dout;
   bit                   ovf_exp;
   int                   nvec;
   int                   nerr;

   fir_mac_seq #(.NTAPS(NTAPS), .OW(OW), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst), .din(din), .stb(stb),
      .sr_d(sr_d), .sr_ce(sr_ce), .sr_a(sr_a), .sr_y(sr_y),
      .ca(ca), .coef(coef), .dout(dout), .vld(vld), .busy(busy), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External delay line: not reset by rst, only by the bench at time zero.
   always @(posedge clk) begin
      if (srl_clr) begin
         for (int i = 0; i < 32; i++) srl[i] <= '0;
      end else if (sr_ce) begin
         for (int i = 31; i > 0; i--) srl[i] <= srl[i-1];
         srl[0] <= $signed(sr_d);
      end
   end
   assign sr_y = srl[sr_a];
   assign coef = ctab[ca];

   task automatic chk(input string tag, input longint got, input longint exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint rnd18();
      logic signed [17:0] v;
      v = 18'($urandom);
      return longint'(v);
   endfunction

   function automatic longint model_out();
      longint s;
      s = 0;
      for (int k = 0; k < NTAPS; k++) s += hist[k] * longint'(ctab[k]);
      s = s >>> SHIFT;
      if (s > OMAX) s = OMAX;
      else if (s < OMIN) s = OMIN;
      return s;
   endfunction

   task automatic push_hist(input longint x);
      hist.push_front(x);
      void'(hist.pop_back());
   endtask

   task automatic chk_idle_outs(input string pfx);
      chk({pfx, "_dout"}, dout, 0);
      chk({pfx, "_vld"}, vld, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_ovf"}, ovf, 0);
      chk({pfx, "_sr_ce"}, sr_ce, 0);
      chk({pfx, "_sr_a"}, sr_a, 0);
      chk({pfx, "_ca"}, ca, 0);
      chk({pfx, "_sr_d"}, sr_d, 0);
   endtask

   // One sample from stb to vld; cycle n is the cycle following edge En.
   task automatic do_sample(input longint x, input bit detail, input int ovr_at);
      longint e;
      int     n;
      bit     done;
      push_hist(x);
      e = model_out();
      din = 18'(x);
      stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      n = 0;
      done = 0;
      while (!done) begin
         if (vld) begin
            chk("latency", n, LAT);
            chk("dout", dout, e);
            chk("busy_at_vld", busy, 0);
            done = 1;
         end else if (n > LAT + 8) begin
            chk("vld_timeout", 0, 1);
            done = 1;
         end else begin
            if (detail) begin
               chk("sr_ce", sr_ce, longint'(n == 0));
               chk("busy", busy, 1);
               chk("dout_hold", dout, prev_dout);
               chk("ovf", ovf, ovf_exp);
               if (n == 0) chk("sr_d", longint'($signed(sr_d)), x);
               if (n >= 1 && n <= NTAPS) begin
                  chk("sr_a", sr_a, n - 1);
                  chk("ca", ca, n - 1);
               end
            end
            stb = (n == ovr_at);
            if (stb) din = 18'($urandom);
            @(negedge clk);
            n++;
            if (ovr_at >= 0 && n == ovr_at + 1) ovf_exp = 1;
         end
      end
      stb = 1'b0;
      prev_dout = e;
      if (detail) begin
         @(negedge clk);
         chk("vld_pulse", vld, 0);
         chk("dout_after", dout, e);
      end
   endtask

   initial begin
      int cnt;
      nvec = 0;
      nerr = 0;
      ovf_exp = 0;
      prev_dout = 0;
      for (int k = 0; k < NTAPS; k++) hist.push_back(0);
      for (int k = 0; k < 32; k++) ctab[k] = '0;
      rst = 1'b1;
      stb = 1'b0;
      din = '0;
      srl_clr = 1'b1;
      repeat (3) @(negedge clk);
      srl_clr = 1'b0;
      chk_idle_outs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single detailed sample with random coefficients
      for (int k = 0; k < 32; k++) ctab[k] = 18'(rnd18());
      do_sample(rnd18(), 1, -1);

      // DC ramp
      for (int i = 0; i < NTAPS; i++) do_sample(0, 0, -1);
      for (int k = 0; k < 32; k++) ctab[k] = 18'sd65536;
      for (int n = 1; n <= NTAPS; n++) begin
         do_sample(100, 0, -1);
         chk("dc_ramp", dout, 100 * n);
      end
      do_sample(100, 0, -1);
      chk("dc_steady", dout, 3200);

      // Impulse
      for (int i = 0; i < NTAPS; i++) do_sample(0, 0, -1);
      for (int k = 0; k < 32; k++) ctab[k] = 18'(4096 * k);
      for (int j = 0; j < NTAPS + 4; j++) begin
         do_sample(j == 0 ? 16 : 0, 0, -1);
         chk("impulse", dout, j < NTAPS ? j : 0);
      end

      // Saturation and large negative without saturation
      for (int k = 0; k < 32; k++) ctab[k] = -18'sd131072;
      for (int i = 0; i < NTAPS; i++) do_sample(-131072, 0, -1);
      chk("sat_pos", dout, OMAX);
      for (int i = 0; i < NTAPS; i++) do_sample(131071, 0, -1);
      chk("neg_nosat", dout, (-longint'(32) * 131072 * 131071) >>> SHIFT);

      // Random coefficients and samples with random idle gaps
      for (int k = 0; k < 32; k++) ctab[k] = 18'(rnd18());
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         case ($urandom_range(0, 3))
            0: do_sample(131071, 0, -1);
            1: do_sample(-131072, 0, -1);
            default: do_sample(rnd18(), 0, -1);
         endcase
      end

      // Overrun: ignored stb, sticky flag, following sample still correct
      chk("ovf_before", ovf, 0);
      do_sample(rnd18(), 1, 10);
      do_sample(rnd18(), 0, -1);
      chk("ovf_sticky", ovf, 1);

      // Reset in the middle of a sweep: sample already sits in the delay line
      push_hist(rnd18());
      din = 18'(hist[0]);
      stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle_outs("midrst");
      rst = 1'b0;
      ovf_exp = 0;
      prev_dout = 0;
      cnt = 0;
      repeat (LAT + 8) begin
         @(negedge clk);
         if (vld || busy) cnt++;
      end
      chk("no_vld_after_rst", cnt, 0);
      do_sample(rnd18(), 1, -1);
      do_sample(rnd18(), 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
